// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   state_e       : RUN / HALTED sequencer states
//   redir_kind_e  : which control class steers the next PC
//   PC_W, PC_STEP : PC width and sequential increment
package pc_seq_pkg;

  localparam int unsigned PC_W    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    JR     = 2'd1,
    JUMP   = 2'd2,
    BRANCH = 2'd3
  } redir_kind_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/data bundle between decode, the PC sequencer and instruction fetch.
//   master : decode side (drives in_*, observes out_*)
//   slave  : pc_sequencer side (consumes in_*, drives out_*)
//   Parameter CNT_W sets the width of the statistics counters.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  import pc_seq_pkg::*;

  logic                in_J;
  logic                in_JW;
  logic                in_JR;
  logic                in_BEQ;
  logic                in_BNE;
  logic                in_BGEZ;
  logic                in_equal;
  logic [PC_W-1:0]     in_rs_value;
  logic [15:0]         in_imm16;
  logic [25:0]         in_target26;
  logic                in_stall;
  logic                in_halt;
  logic                in_go;

  logic [PC_W-1:0]     out_pc;
  logic                out_redirect;
  logic                out_link_we;
  logic [PC_W-1:0]     out_link_data;
  logic                out_halted;
  logic [CNT_W-1:0]    out_cnt_cycles;
  logic [CNT_W-1:0]    out_cnt_uncond;
  logic [CNT_W-1:0]    out_cnt_taken;

  modport master (
    output in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ, in_equal,
           in_rs_value, in_imm16, in_target26, in_stall, in_halt, in_go,
    input  out_pc, out_redirect, out_link_we, out_link_data, out_halted,
           out_cnt_cycles, out_cnt_uncond, out_cnt_taken
  );

  modport slave (
    input  in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ, in_equal,
           in_rs_value, in_imm16, in_target26, in_stall, in_halt, in_go,
    output out_pc, out_redirect, out_link_we, out_link_data, out_halted,
           out_cnt_cycles, out_cnt_uncond, out_cnt_taken
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on in_inc, sticks at all-ones.
//   in_clk, in_rst_n : clock, asynchronous active-low reset (clears count)
//   in_inc           : increment request
//   out_count        : current count (registered)
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_inc,
  output logic [W-1:0] out_count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (in_inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / next-PC stage: resolves J, JW, JR, BEQ, BNE, BGEZ against
// register data, owns the PC and a RUN/HALTED FSM, and produces the JW link.
//   in_clk, in_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : decoded controls, operands, stall/halt/go in;
//                      PC, redirect, link write, halted, statistics out
// Build option: define BRANCH_STATS_EN to build the cycle / unconditional /
// taken-branch saturating counters; otherwise out_cnt_* are tied to zero.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  pc_sequencer_if.slave  bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc4, br_tgt, jmp_tgt, jr_tgt, tgt_c;
  state_e          state_q, state_d;
  redir_kind_e     kind;
  logic            br_taken;
  logic            redirect_c;
  logic            advance;

  assign pc4     = pc_q + PC_STEP;
  assign br_tgt  = pc4 + {{14{bus.in_imm16[15]}}, bus.in_imm16, 2'b00};
  assign jmp_tgt = {pc4[31:28], bus.in_target26, 2'b00};
  assign jr_tgt  = bus.in_rs_value & ~PC_W'(3);

  // Priority pick: only the highest asserted control is evaluated.
  always_comb begin : kind_sel
    kind     = NONE;
    br_taken = 1'b0;
    if (bus.in_JR) begin
      kind = JR;
    end else if (bus.in_J || bus.in_JW) begin
      kind = JUMP;
    end else if (bus.in_BEQ) begin
      kind     = BRANCH;
      br_taken = bus.in_equal;
    end else if (bus.in_BNE) begin
      kind     = BRANCH;
      br_taken = !bus.in_equal;
    end else if (bus.in_BGEZ) begin
      kind     = BRANCH;
      br_taken = !bus.in_rs_value[31];
    end
  end

  // Redirect target; falls back to PC+4 when nothing redirects.
  always_comb begin : tgt_sel
    tgt_c      = pc4;
    redirect_c = 1'b0;
    case (kind)
      JR: begin
        tgt_c      = jr_tgt;
        redirect_c = 1'b1;
      end
      JUMP: begin
        tgt_c      = jmp_tgt;
        redirect_c = 1'b1;
      end
      BRANCH: begin
        if (br_taken) begin
          tgt_c      = br_tgt;
          redirect_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Halt wins over any concurrent redirect; stall holds everything.
  assign advance = (state_q == RUN) && !bus.in_stall && !bus.in_halt;

  // Next state and next PC.
  always_comb begin : fsm_next
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        if (bus.in_halt && !bus.in_stall) state_d = HALTED;
        if (advance)                      pc_d    = tgt_c;
      end
      HALTED: begin
        if (bus.in_go) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.out_pc        = pc_q;
  assign bus.out_halted    = (state_q == HALTED);
  assign bus.out_redirect  = redirect_c;
  assign bus.out_link_we   = bus.in_JW && !bus.in_JR && advance;
  assign bus.out_link_data = pc4;

`ifdef BRANCH_STATS_EN
  logic inc_cycles, inc_uncond, inc_taken;

  assign inc_cycles = (state_q == RUN);
  assign inc_uncond = advance && ((kind == JR) || (kind == JUMP));
  assign inc_taken  = advance && (kind == BRANCH) && br_taken;

  sat_counter #(.W(CNT_W)) u_cnt_cycles (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_inc(inc_cycles), .out_count(bus.out_cnt_cycles)
  );
  sat_counter #(.W(CNT_W)) u_cnt_uncond (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_inc(inc_uncond), .out_count(bus.out_cnt_uncond)
  );
  sat_counter #(.W(CNT_W)) u_cnt_taken (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_inc(inc_taken), .out_count(bus.out_cnt_taken)
  );
`else
  assign bus.out_cnt_cycles = {CNT_W{1'b0}};
  assign bus.out_cnt_uncond = {CNT_W{1'b0}};
  assign bus.out_cnt_taken  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a reference model predicts combinational
// outputs each step and pushes next-cycle PC/state/counters to a scoreboard
// queue that is popped and compared after the clock edge.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;

  pc_sequencer_if #(.CNT_W(CW)) bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .in_clk  (clk),
    .in_rst_n(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic          halted;
    logic [CW-1:0] cyc;
    logic [CW-1:0] unc;
    logic [CW-1:0] tkn;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [31:0]   m_pc;
  logic          m_halted;
  logic [CW-1:0] m_cyc, m_unc, m_tkn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  function automatic logic [CW-1:0] cnt_exp(input logic [CW-1:0] v);
`ifdef BRANCH_STATS_EN
    return v;
`else
    return (v & '0);
`endif
  endfunction

  task automatic clr();
    bus.in_J = 0; bus.in_JW = 0; bus.in_JR = 0;
    bus.in_BEQ = 0; bus.in_BNE = 0; bus.in_BGEZ = 0;
    bus.in_equal = 0; bus.in_rs_value = '0; bus.in_imm16 = '0;
    bus.in_target26 = '0; bus.in_stall = 0; bus.in_halt = 0; bus.in_go = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 1'b0;
    m_cyc = '0; m_unc = '0; m_tkn = '0;
    sb.delete();
  endtask

  task automatic chk_counters(input string tag, input logic [CW-1:0] c, input logic [CW-1:0] u,
                              input logic [CW-1:0] t);
    chk({tag, ":cnt_cycles"}, 32'(bus.out_cnt_cycles), 32'(cnt_exp(c)));
    chk({tag, ":cnt_uncond"}, 32'(bus.out_cnt_uncond), 32'(cnt_exp(u)));
    chk({tag, ":cnt_taken"},  32'(bus.out_cnt_taken),  32'(cnt_exp(t)));
  endtask

  // One clock of stimulus using the currently driven inputs.
  task automatic step(input string tag);
    logic [31:0] pc4, tgt;
    logic        jmp, brt, adv;
    exp_t        e;
    #1;
    pc4 = m_pc + 32'd4;
    tgt = pc4;
    jmp = 1'b0;
    brt = 1'b0;
    if (bus.in_JR) begin
      jmp = 1'b1;
      tgt = {bus.in_rs_value[31:2], 2'b00};
    end else if (bus.in_J || bus.in_JW) begin
      jmp = 1'b1;
      tgt = {pc4[31:28], bus.in_target26, 2'b00};
    end else begin
      if (bus.in_BEQ)       brt = bus.in_equal;
      else if (bus.in_BNE)  brt = !bus.in_equal;
      else if (bus.in_BGEZ) brt = !bus.in_rs_value[31];
      if (brt) tgt = pc4 + {{14{bus.in_imm16[15]}}, bus.in_imm16, 2'b00};
    end
    adv = !m_halted && !bus.in_stall && !bus.in_halt;

    chk({tag, ":redirect"},  32'(bus.out_redirect), 32'(jmp | brt));
    chk({tag, ":link_we"},   32'(bus.out_link_we),  32'(bus.in_JW & !bus.in_JR & adv));
    chk({tag, ":link_data"}, bus.out_link_data,     pc4);

    if (!m_halted)  m_cyc = sat_inc(m_cyc);
    if (adv && jmp) m_unc = sat_inc(m_unc);
    if (adv && brt) m_tkn = sat_inc(m_tkn);
    if (adv)        m_pc  = tgt;
    if (!m_halted) begin
      if (bus.in_halt && !bus.in_stall) m_halted = 1'b1;
    end else if (bus.in_go) begin
      m_halted = 1'b0;
    end

    e.pc = m_pc; e.halted = m_halted;
    e.cyc = cnt_exp(m_cyc); e.unc = cnt_exp(m_unc); e.tkn = cnt_exp(m_tkn);
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ":pc"},     bus.out_pc,              e.pc);
    chk({tag, ":halted"}, 32'(bus.out_halted),     32'(e.halted));
    chk({tag, ":cyc"},    32'(bus.out_cnt_cycles), 32'(e.cyc));
    chk({tag, ":unc"},    32'(bus.out_cnt_uncond), 32'(e.unc));
    chk({tag, ":tkn"},    32'(bus.out_cnt_taken),  32'(e.tkn));
  endtask

  task automatic do_reset(input string tag);
    clr();
    rst_n = 1'b0;
    #1;
    chk({tag, ":pc"},     bus.out_pc,          32'h0);
    chk({tag, ":halted"}, 32'(bus.out_halted), 32'h0);
    chk({tag, ":redir"},  32'(bus.out_redirect), 32'h0);
    chk({tag, ":lnk_we"}, 32'(bus.out_link_we),  32'h0);
    chk_counters(tag, '0, '0, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    model_reset();
    do_reset("por");

    // Sequential fetch, then BEQ taken backwards and not taken
    repeat (4) step("seq");
    chk("seq_pc", bus.out_pc, 32'h10);
    bus.in_BEQ = 1; bus.in_imm16 = 16'hFFFC; bus.in_equal = 1;
    step("beq_t");
    chk("beq_t_pc", bus.out_pc, 32'h04);
    chk_counters("beq_t", 4'd5, 4'd0, 4'd1);
    clr();
    repeat (3) step("seq2");
    bus.in_BEQ = 1; bus.in_imm16 = 16'hFFFC; bus.in_equal = 0;
    step("beq_nt");
    chk("beq_nt_pc", bus.out_pc, 32'h14);

    // Jump-and-link from 0x100
    do_reset("rst2");
    bus.in_BEQ = 1; bus.in_equal = 1; bus.in_imm16 = 16'h003F;
    step("beq_fwd");
    chk("beq_fwd_pc", bus.out_pc, 32'h100);
    clr();
    bus.in_JW = 1; bus.in_target26 = 26'h0000123;
    #1;
    chk("jw_link_we",   32'(bus.out_link_we), 32'h1);
    chk("jw_link_data", bus.out_link_data,    32'h104);
    step("jw");
    chk("jw_pc", bus.out_pc, 32'h48C);
    chk_counters("jw", 4'd2, 4'd1, 4'd1);

    // JR beats a concurrent BEQ
    clr();
    bus.in_JR = 1; bus.in_rs_value = 32'h2003; bus.in_BEQ = 1; bus.in_equal = 1;
    step("jr");
    chk("jr_pc", bus.out_pc, 32'h2000);
    chk_counters("jr", 4'd3, 4'd2, 4'd1);

    // Stalled jump-and-link holds for three cycles, then retires
    clr();
    bus.in_JW = 1; bus.in_target26 = 26'h40; bus.in_stall = 1;
    repeat (3) step("stall");
    chk("stall_pc", bus.out_pc, 32'h2000);
    chk("stall_lnk", 32'(bus.out_link_we), 32'h0);
    chk_counters("stall", 4'd6, 4'd2, 4'd1);
    bus.in_stall = 0;
    step("unstall");
    chk("unstall_pc", bus.out_pc, 32'h100);

    // Halt over a jump, ignored halt while HALTED, resume with go
    clr();
    bus.in_J = 1; bus.in_target26 = 26'h200; bus.in_halt = 1;
    step("halt");
    chk("halt_st", 32'(bus.out_halted), 32'h1);
    chk("halt_pc", bus.out_pc, 32'h100);
    repeat (2) step("halted");
    clr();
    bus.in_go = 1;
    step("go");
    bus.in_go = 0;
    repeat (3) step("resume");
    chk("resume_pc", bus.out_pc, 32'h10C);
    bus.in_halt = 1; bus.in_stall = 1;
    step("halt_stall");
    chk("halt_stall_st", 32'(bus.out_halted), 32'h0);

    // Remaining branch flavours and priority
    clr();
    bus.in_BNE = 1; bus.in_equal = 0; bus.in_imm16 = 16'h0004;
    step("bne_t");
    clr();
    bus.in_BEQ = 1; bus.in_BNE = 1; bus.in_equal = 0; bus.in_imm16 = 16'h0010;
    step("beq_over_bne");
    clr();
    bus.in_BGEZ = 1; bus.in_rs_value = 32'h8000_0000; bus.in_imm16 = 16'h0002;
    step("bgez_nt");
    bus.in_rs_value = 32'h0000_0005;
    step("bgez_t");
    clr();
    bus.in_J = 1; bus.in_BEQ = 1; bus.in_equal = 1; bus.in_target26 = 26'h3FF_FFFF;
    step("j_over_beq");

    // PC wrap
    clr();
    bus.in_JR = 1; bus.in_rs_value = 32'hFFFF_FFFE;
    step("jr_top");
    chk("jr_top_pc", bus.out_pc, 32'hFFFF_FFFC);
    clr();
    step("wrap");
    chk("wrap_pc", bus.out_pc, 32'h0);

    // Counter saturation
    repeat (20) step("sat");
`ifdef BRANCH_STATS_EN
    chk("sat_cycles", 32'(bus.out_cnt_cycles), 32'd15);
`else
    chk("sat_cycles", 32'(bus.out_cnt_cycles), 32'd0);
`endif

    // Asynchronous reset mid-cycle while HALTED
    bus.in_halt = 1;
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc",     bus.out_pc,          32'h0);
    chk("arst_halted", 32'(bus.out_halted), 32'h0);
    chk_counters("arst", '0, '0, '0);
    model_reset();
    clr();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step("post_rst");
    chk("post_rst_pc", bus.out_pc, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
